quadrature_step_generator: RTL and testbench

//  Transmit side of the rotary-encoder interface: emits a glitch-free 2-bit Gray quadrature

---
 rtl/quadrature_step_generator.sv | 144 ++++++++++++++
 tb/tb_quadrature_step_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_generator.sv
// Quadrature step generator: emits a Gray-coded (a, b) pair, one transition per step,
// for a commanded step count, direction and transition period.
module quadrature_step_generator #(
  parameter int REG_LEN    = 8,
  parameter int PERIOD_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [REG_LEN-1:0]    steps,
  input  logic [PERIOD_LEN-1:0] period,
  input  logic                  abort,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic [REG_LEN-1:0]    remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic                  dir_reg;
  logic [PERIOD_LEN-1:0] reload_reg;
  logic [PERIOD_LEN-1:0] timer_reg;
  logic [REG_LEN-1:0]    remaining_reg;
  logic                  a_reg;
  logic                  b_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  a_next;
  logic                  b_next;
  logic                  busy_next;
  logic                  done_next;
  logic [PERIOD_LEN-1:0] reload_in;
  logic                  cmd_accept;
  logic                  step_due;
  logic                  last_step;

  // A period of 0 behaves like 1, so the reload value saturates at zero.
  assign reload_in  = (period == '0) ? '0 : period - 1'b1;
  assign cmd_accept = (state_reg == IDLE) && start && !abort;
  assign step_due   = (state_reg == RUN) && !abort && (timer_reg == '0);
  assign last_step  = step_due && (remaining_reg == REG_LEN'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          state_next = (steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge
  always_comb begin
    busy_next = (state_reg == RUN) && !abort;
    done_next = (state_reg == DONE);
    a_next    = a_reg;
    b_next    = b_reg;
    if (step_due) begin
      // CW walks 00->10->11->01, CCW walks the same ring backwards.
      if (dir_reg) begin
        a_next = ~b_reg;
        b_next = a_reg;
      end else begin
        a_next = b_reg;
        b_next = ~a_reg;
      end
    end
  end

  // Command capture, timer and step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_reg       <= 1'b0;
      reload_reg    <= '0;
      timer_reg     <= '0;
      remaining_reg <= '0;
    end else begin
      if (cmd_accept) begin
        dir_reg       <= dir;
        reload_reg    <= reload_in;
        timer_reg     <= reload_in;
        remaining_reg <= steps;
      end else if ((state_reg == RUN) && !abort) begin
        timer_reg <= (timer_reg == '0) ? reload_reg : timer_reg - 1'b1;
        if (step_due) begin
          remaining_reg <= remaining_reg - 1'b1;
        end
      end
    end
  end

  // Registered outputs; phase survives abort and new commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= 1'b0;
      b_reg    <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      a_reg    <= a_next;
      b_reg    <= b_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign a         = a_reg;
  assign b         = b_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Directed bench for quadrature_step_generator: command timing, phase continuity,
// abort handling, full-count commands, decoder loopback and asynchronous reset.
module tb_quadrature_step_generator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [7:0]  steps;
  logic [15:0] period;
  logic        abort;
  logic        a;
  logic        b;
  logic        busy;
  logic        done;
  logic [7:0]  remaining;

  int checks = 0;
  int errors = 0;
  int ph_idx = 0;
  int dec_count = 0;
  int dec0;
  logic [1:0] last_ab = 2'b00;
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_step_generator #(.REG_LEN(8), .PERIOD_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .steps     (steps),
    .period    (period),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int dec_delta(input logic [1:0] prev, input logic [1:0] cur);
    int d;
    d = (idx_of(cur) - idx_of(prev) + 4) % 4;
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  // Reference quadrature decoder for the loopback test
  always @(negedge clk) begin
    last_ab   <= {a, b};
    dec_count <= dec_count + dec_delta(last_ab, {a, b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int idx, input logic [7:0] rem);
    check({tag, "_ab"},   {30'd0, a, b}, {30'd0, seq[idx]});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rem"},  {24'd0, remaining}, {24'd0, rem});
  endtask

  // Issue one command and check every edge through the done pulse.
  task automatic do_cmd(input string tag, input bit d, input int s, input int p);
    int pp;
    int last;
    int n;
    int exp_idx;
    pp = (p == 0) ? 1 : p;
    $display("cmd %s dir=%0d steps=%0d period=%0d phase=%0d", tag, d, s, p, ph_idx);
    dir = d; steps = s[7:0]; period = p[15:0]; start = 1'b1;
    tick();
    start = 1'b0; dir = ~d; steps = 8'hA5; period = 16'd2;
    last = s * pp + 1;
    for (int e = 1; e <= last; e++) begin
      start = (e == 2) && (s * pp >= 2);
      tick();
      n = (e / pp < s) ? e / pp : s;
      exp_idx = d ? (ph_idx + n) % 4 : (ph_idx + 1024 - n) % 4;
      check({tag, "_ab"},   {30'd0, a, b}, {30'd0, seq[exp_idx]});
      check({tag, "_busy"}, {31'd0, busy}, {31'd0, (s > 0) && (e <= s * pp)});
      check({tag, "_done"}, {31'd0, done}, {31'd0, e == s * pp + 1});
      check({tag, "_rem"},  {24'd0, remaining}, s - n);
    end
    start = 1'b0;
    ph_idx = d ? (ph_idx + s) % 4 : (ph_idx + 1024 - s) % 4;
    tick();
    check_idle({tag, "_after"}, ph_idx, 8'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; period = '0; abort = 1'b0;
    #2;
    check_idle("reset", 0, 8'd0);
    #10 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle", 0, 8'd0);
    end

    do_cmd("cw4_p3", 1'b1, 4, 3);
    do_cmd("ccw2_p0", 1'b0, 2, 0);
    do_cmd("cw2_p0", 1'b1, 2, 0);
    do_cmd("zero", 1'b1, 0, 5);

    // Abort after the second transition; start while busy must be ignored
    $display("cmd abort dir=1 steps=8 period=4 phase=%0d", ph_idx);
    dir = 1'b1; steps = 8'd8; period = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      start = (e == 3);
      steps = (e == 3) ? 8'd20 : 8'd8;
      tick();
    end
    start = 1'b0;
    check("abort_pre_ab",  {30'd0, a, b}, {30'd0, seq[2]});
    check("abort_pre_rem", {24'd0, remaining}, 32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ph_idx = 2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("abort_hold", ph_idx, 8'd6);
    end

    $display("cmd abort_start dir=1 steps=3 period=1 phase=%0d", ph_idx);
    steps = 8'd3; period = 16'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_start", ph_idx, 8'd6);
    end

    // Abort during DONE must not cut the done pulse
    $display("cmd abort_in_done dir=1 steps=1 period=1 phase=%0d", ph_idx);
    dir = 1'b1; steps = 8'd1; period = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ph_idx = 3;
    check("done_abort_done", {31'd0, done}, 32'd1);
    check("done_abort_busy", {31'd0, busy}, 32'd0);
    check("done_abort_ab",   {30'd0, a, b}, {30'd0, seq[3]});
    tick();
    check_idle("done_abort_after", ph_idx, 8'd0);

    do_cmd("full255", 1'b1, 255, 1);

    // Loopback into a reference decoder
    dec0 = dec_count;
    do_cmd("loop_cw", 1'b1, 5, 64);
    check("loop_cw_count", dec_count - dec0, 32'd5);
    do_cmd("loop_ccw", 1'b0, 5, 64);
    check("loop_ccw_count", dec_count, dec0);

    // Asynchronous reset in the middle of a command
    $display("cmd reset_mid dir=1 steps=5 period=64 phase=%0d", ph_idx);
    dir = 1'b1; steps = 8'd5; period = 16'd64; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_rem",  {24'd0, remaining}, 32'd4);
    rst = 1'b0;
    #1;
    ph_idx = 0;
    check_idle("rst_mid", ph_idx, 8'd0);
    #3 rst = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i % 10 == 9) check_idle("rst_after", ph_idx, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
